omsp_per_master: RTL and testbench
==================================

OMSP_PER_MASTER -- requirements
Module: omsp_per_master

Interface
REQ-001 SHALL have ports: mclk in 1, system clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset_n in 1, asynchronous active-low reset.
REQ-003 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_addr in 9 (byte address); cmd_wr in 1; cmd_byte in 1; cmd_wdata in 16; cmd_len in 4 (beats minus 1); cmd_rmw in 2 (00 plain, 01 bit-set, 10 bit-clear).
REQ-004 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out 16; rsp_last out 1; busy out 1.
REQ-005 SHALL have peripheral-bus initiator ports: per_addr out 8 (word address); per_din out 16; per_en out 1; per_we out 2; per_dout in 16 (combinational responder data, same cycle as per_en).

Function
REQ-006 FSM SHALL have states IDLE, ACCESS, RESP, plus RMW_WR when RMW is compiled in.
REQ-007 cmd_ready SHALL be 1 only in IDLE; busy SHALL equal ~cmd_ready.
REQ-008 In IDLE, cmd_valid=1 SHALL capture all cmd_* fields and enter ACCESS next cycle; cmd_valid is ignored outside IDLE.
REQ-009 ACCESS SHALL last exactly one cycle with per_en=1 and per_addr=addr[8:1].
REQ-010 Word access: per_we=11 on write, 00 on read; addr[0] forced to 0; per_din=wdata.
REQ-011 Byte write: per_we=01 with per_din={8'h00,wdata[7:0]} for even addr; per_we=10 with per_din={wdata[7:0],8'h00} for odd addr.
REQ-012 Read beat SHALL register per_dout at end of ACCESS; rsp_rdata = word, or zero-extended [7:0] (even) / [15:8] (odd) for byte reads; write beats return rsp_rdata=0.
REQ-013 Outside ACCESS/RMW_WR, per_en, per_we, per_addr, per_din SHALL all be 0 (OR-bus safe).
REQ-014 RESP SHALL assert rsp_valid, holding rsp_rdata/rsp_last stable until rsp_valid&rsp_ready.
REQ-015 On handshake: if beats remain, address += 1 (byte) or 2 (word), modulo 512, and enter ACCESS; else enter IDLE.
REQ-016 A command SHALL produce exactly cmd_len+1 beats; rsp_last=1 only on the final beat; writes in a burst reuse wdata (fill).
REQ-017 Latency: command accepted cycle N -> per_en cycle N+1 -> rsp_valid cycle N+2; with rsp_ready tied high, one beat per 2 cycles.

Reset
REQ-018 reset_n=0 SHALL asynchronously force IDLE, abort any burst, and clear rsp_valid, rsp_rdata, rsp_last, per_en, per_we, per_addr, per_din; cmd_ready=1, busy=0 during and after reset.
REQ-019 No partial beat SHALL complete after reset release; the first per_en requires a new command.

Configuration
REQ-020 Macro PMST_RMW_EN SHALL compile in read-modify-write: cmd_rmw 01/10 performs ACCESS as a read, then RMW_WR one cycle later writing rdata|wdata (01) or rdata&~wdata (10) with the same lanes; the response returns the original read value.
REQ-021 Without PMST_RMW_EN, cmd_rmw SHALL be ignored, RMW_WR SHALL not exist, and cmd_wr alone selects the direction.

Structure
REQ-022 Package omsp_pmst_pkg SHALL hold the state encoding, cmd_rmw opcodes, and the beat-counter width (4).
REQ-023 Byte-lane steering (REQ-011/012) SHALL be sub-module omsp_pmst_lane, purely combinational.

Verification
REQ-024 Word write 0x058, data 0x000E, len 0 -> one cycle per_addr=0x2C, per_we=11, per_din=0x000E; one rsp with rsp_last=1, rdata=0.
REQ-025 Byte write 0x057, data 0x0030 -> per_addr=0x2B, per_we=10, per_din=0x3000.
REQ-026 Word read 0x056, len 2, responder returns 0x1111/0x2222/0x3333 -> per_addr 0x2B, 0x2C, 0x2D; rsp_rdata in that order; rsp_last on the third beat only.
REQ-027 Byte read burst at 0x1FF, len 1, rsp_ready low 3 cycles per beat -> addresses 0x1FF then 0x000 (wrap); rsp held stable while stalled; no per_en during stall.
REQ-028 reset_n pulsed low in RESP of beat 2 of a 4-beat burst -> all outputs 0 immediately; no further per_en until a new command.
REQ-029 With PMST_RMW_EN: bit-set 0x058, wdata 0x0002, responder holds 0x000C -> read cycle then write per_din=0x000E; rsp_rdata=0x000C.

Source files
------------

// File: rtl/omsp_pmst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : omsp_pmst_pkg
// Brief    : Shared constants for the peripheral-bus master: FSM encoding,
//            read-modify-write opcodes, beat-counter width.
//            RMW_WR exists only when PMST_RMW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package omsp_pmst_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_ACCESS = 2'd1;
    localparam logic [1:0] C_ST_RESP   = 2'd2;
`ifdef PMST_RMW_EN
    localparam logic [1:0] C_ST_RMW_WR = 2'd3;
`endif

    localparam logic [1:0] C_RMW_PLAIN = 2'b00;
    localparam logic [1:0] C_RMW_SET   = 2'b01;
    localparam logic [1:0] C_RMW_CLR   = 2'b10;

    // Byte bursts step by one, word bursts by two; the 9-bit sum wraps at 512.
    function automatic logic [8:0] next_addr(input logic [8:0] addr, input logic is_byte);
        return addr + (is_byte ? 9'd1 : 9'd2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/omsp_pmst_lane.sv
`default_nettype none
// ============================================================================
// Module   : omsp_pmst_lane
// Brief    : Combinational byte-lane steering for writes (we/din) and
//            read-data extraction with zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module omsp_pmst_lane
    import omsp_pmst_pkg::*;
(
    input  logic        i_write,
    input  logic        i_byte,
    input  logic        i_addr0,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_per_dout,
    output logic [1:0]  o_we,
    output logic [15:0] o_din,
    output logic [15:0] o_rdata
);

    always_comb begin
        o_we    = 2'b00;
        o_din   = 16'h0000;
        o_rdata = 16'h0000;
        if (i_byte) begin
            if (i_write) begin
                o_we  = i_addr0 ? 2'b10 : 2'b01;
                o_din = i_addr0 ? {i_wdata[7:0], 8'h00} : {8'h00, i_wdata[7:0]};
            end else begin
                o_rdata = i_addr0 ? {8'h00, i_per_dout[15:8]} : {8'h00, i_per_dout[7:0]};
            end
        end else begin
            if (i_write) begin
                o_we  = 2'b11;
                o_din = i_wdata;
            end else begin
                o_rdata = i_per_dout;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/omsp_per_master.sv
`default_nettype none
// ============================================================================
// Module   : omsp_per_master
// Brief    : Command-driven burst master for the openMSP430 peripheral bus.
//            Define PMST_RMW_EN to compile in bit-set/bit-clear RMW.
// Revision : 1.0 - initial release
// ============================================================================
module omsp_per_master
    import omsp_pmst_pkg::*;
(
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [8:0]  cmd_addr,
    input  logic        cmd_wr,
    input  logic        cmd_byte,
    input  logic [15:0] cmd_wdata,
    input  logic [3:0]  cmd_len,
    input  logic [1:0]  cmd_rmw,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_last,
    output logic        busy,
    output logic [7:0]  per_addr,
    output logic [15:0] per_din,
    output logic        per_en,
    output logic [1:0]  per_we,
    input  logic [15:0] per_dout
);

    logic [1:0]       state_q, state_d;
    logic [8:0]       addr_q, addr_d;
    logic             wr_q, wr_d;
    logic             byte_q, byte_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    logic             w_rmw_go;
    logic             w_lane_write;
    logic             w_per_active;
    logic [15:0]      w_lane_wdata;
    logic [1:0]       w_lane_we;
    logic [15:0]      w_lane_din;
    logic [15:0]      w_lane_rdata;

`ifdef PMST_RMW_EN
    logic [1:0] rmw_q, rmw_d;

    assign w_rmw_go = (rmw_q == C_RMW_SET) || (rmw_q == C_RMW_CLR);

    always_comb begin
        rmw_d = rmw_q;
        if (state_q == C_ST_IDLE && cmd_valid) rmw_d = cmd_rmw;
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) rmw_q <= C_RMW_PLAIN;
        else          rmw_q <= rmw_d;
    end

    // rdata_q already holds the lane-extracted read value, so byte RMW works on [7:0].
    always_comb begin
        w_lane_wdata = wdata_q;
        if (state_q == C_ST_RMW_WR)
            w_lane_wdata = (rmw_q == C_RMW_SET) ? (rdata_q | wdata_q) : (rdata_q & ~wdata_q);
    end

    assign w_lane_write = (state_q == C_ST_RMW_WR) || (state_q == C_ST_ACCESS && wr_q && !w_rmw_go);
    assign w_per_active = (state_q == C_ST_ACCESS) || (state_q == C_ST_RMW_WR);
`else
    logic unused_rmw;
    assign unused_rmw   = ^cmd_rmw;
    assign w_rmw_go     = 1'b0;
    assign w_lane_wdata = wdata_q;
    assign w_lane_write = (state_q == C_ST_ACCESS) && wr_q;
    assign w_per_active = (state_q == C_ST_ACCESS);
`endif

    omsp_pmst_lane u_lane (
        .i_write    (w_lane_write),
        .i_byte     (byte_q),
        .i_addr0    (addr_q[0]),
        .i_wdata    (w_lane_wdata),
        .i_per_dout (per_dout),
        .o_we       (w_lane_we),
        .o_din      (w_lane_din),
        .o_rdata    (w_lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        byte_d  = byte_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            C_ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_byte ? cmd_addr : {cmd_addr[8:1], 1'b0};
                    wr_d    = cmd_wr;
                    byte_d  = cmd_byte;
                    wdata_d = cmd_wdata;
                    cnt_d   = cmd_len;
                    state_d = C_ST_ACCESS;
                end
            end
            C_ST_ACCESS: begin
                rdata_d = w_lane_write ? 16'h0000 : w_lane_rdata;
                last_d  = (cnt_q == '0);
`ifdef PMST_RMW_EN
                state_d = w_rmw_go ? C_ST_RMW_WR : C_ST_RESP;
`else
                state_d = C_ST_RESP;
`endif
            end
`ifdef PMST_RMW_EN
            C_ST_RMW_WR: state_d = C_ST_RESP;
`endif
            C_ST_RESP: begin
                if (rsp_ready) begin
                    if (cnt_q != '0) begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        addr_d  = next_addr(addr_q, byte_q);
                        state_d = C_ST_ACCESS;
                    end else begin
                        state_d = C_ST_IDLE;
                    end
                end
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= C_ST_IDLE;
            addr_q  <= 9'h000;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Bus outputs are gated to zero outside an access so the bus can be OR-combined.
    assign per_en    = w_per_active;
    assign per_we    = w_per_active ? w_lane_we : 2'b00;
    assign per_addr  = w_per_active ? addr_q[8:1] : 8'h00;
    assign per_din   = w_per_active ? w_lane_din : 16'h0000;

    assign cmd_ready = (state_q == C_ST_IDLE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = (state_q == C_ST_RESP);
    assign rsp_last  = rsp_valid & last_q;
    assign rsp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_omsp_per_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_omsp_per_master
// Brief    : Directed vector bench for omsp_per_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_omsp_per_master;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_addr = '0;
    logic        cmd_wr = 1'b0;
    logic        cmd_byte = 1'b0;
    logic [15:0] cmd_wdata = '0;
    logic [3:0]  cmd_len = '0;
    logic [1:0]  cmd_rmw = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_rdata;
    logic        rsp_last;
    logic        busy;
    logic [7:0]  per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    logic [15:0] mem [256];

    int n_total = 0;
    int n_pass  = 0;

    always #5 mclk = ~mclk;

    assign per_dout = per_en ? mem[per_addr] : 16'h0000;

    omsp_per_master dut (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_wr    (cmd_wr),
        .cmd_byte  (cmd_byte),
        .cmd_wdata (cmd_wdata),
        .cmd_len   (cmd_len),
        .cmd_rmw   (cmd_rmw),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .per_addr  (per_addr),
        .per_din   (per_din),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_dout  (per_dout)
    );

    typedef struct {
        logic [8:0]  addr;
        logic        wr;
        logic        bt;
        logic [15:0] wdata;
        logic [7:0]  paddr;
        logic [1:0]  we;
        logic [15:0] din;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic issue(input logic [8:0] a, input logic w, input logic b,
                         input logic [15:0] d, input logic [3:0] len, input logic [1:0] rmw);
        @(negedge mclk);
        cmd_addr  = a;
        cmd_wr    = w;
        cmd_byte  = b;
        cmd_wdata = d;
        cmd_len   = len;
        cmd_rmw   = rmw;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge mclk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.addr, v.wr, v.bt, v.wdata, 4'd0, 2'b00);
        chk("acc_en",   {31'd0, per_en}, 32'd1);
        chk("acc_addr", {24'd0, per_addr}, {24'd0, v.paddr});
        chk("acc_we",   {30'd0, per_we}, {30'd0, v.we});
        chk("acc_din",  {16'd0, per_din}, {16'd0, v.din});
        chk("acc_busy", {31'd0, busy}, 32'd1);
        @(posedge mclk); #1;
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, v.rdata});
        chk("rsp_last",  {31'd0, rsp_last}, 32'd1);
        chk("rsp_no_en", {31'd0, per_en}, 32'd0);
        @(posedge mclk); #1;
        chk("back_idle", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h2B] = 16'h1111;
        mem[8'h2C] = 16'h2222;
        mem[8'h2D] = 16'h3333;
        mem[8'hFF] = 16'hBE00;
        mem[8'h00] = 16'h0077;
        mem[8'h01] = 16'h5A5A;

        vecs[0] = '{9'h058, 1'b1, 1'b0, 16'h000E, 8'h2C, 2'b11, 16'h000E, 16'h0000};
        vecs[1] = '{9'h057, 1'b1, 1'b1, 16'h0030, 8'h2B, 2'b10, 16'h3000, 16'h0000};
        vecs[2] = '{9'h056, 1'b1, 1'b1, 16'hFF7A, 8'h2B, 2'b01, 16'h007A, 16'h0000};
        vecs[3] = '{9'h059, 1'b0, 1'b0, 16'hFFFF, 8'h2C, 2'b00, 16'h0000, 16'h2222};
        vecs[4] = '{9'h05A, 1'b0, 1'b1, 16'h0000, 8'h2D, 2'b00, 16'h0000, 16'h0033};
        vecs[5] = '{9'h05B, 1'b0, 1'b1, 16'h0000, 8'h2D, 2'b00, 16'h0000, 16'h0033};
        vecs[6] = '{9'h1FF, 1'b0, 1'b1, 16'h0000, 8'hFF, 2'b00, 16'h0000, 16'h00BE};

        // Reset state
        #2;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_en",    {31'd0, per_en}, 32'd0);
        repeat (2) @(posedge mclk);
        @(negedge mclk) reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Word read burst of three beats, rsp_ready high
        rsp_ready = 1'b1;
        issue(9'h056, 1'b0, 1'b0, 16'h0000, 4'd2, 2'b00);
        for (int k = 0; k < 3; k++) begin
            chk("burst_en",   {31'd0, per_en}, 32'd1);
            chk("burst_addr", {24'd0, per_addr}, 32'h2B + k);
            @(posedge mclk); #1;
            chk("burst_valid", {31'd0, rsp_valid}, 32'd1);
            chk("burst_rdata", {16'd0, rsp_rdata}, 32'h1111 * (k + 1));
            chk("burst_last",  {31'd0, rsp_last}, (k == 2) ? 32'd1 : 32'd0);
            @(posedge mclk); #1;
        end
        chk("burst_idle", {31'd0, cmd_ready}, 32'd1);

        // Byte read burst wrapping 0x1FF -> 0x000 with a stalled consumer
        rsp_ready = 1'b0;
        issue(9'h1FF, 1'b0, 1'b1, 16'h0000, 4'd1, 2'b00);
        for (int k = 0; k < 2; k++) begin
            chk("wrap_en",   {31'd0, per_en}, 32'd1);
            chk("wrap_addr", {24'd0, per_addr}, (k == 0) ? 32'hFF : 32'h00);
            @(posedge mclk); #1;
            for (int s = 0; s < 4; s++) begin
                chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
                chk("stall_rdata", {16'd0, rsp_rdata}, (k == 0) ? 32'h00BE : 32'h0077);
                chk("stall_last",  {31'd0, rsp_last}, (k == 1) ? 32'd1 : 32'd0);
                chk("stall_no_en", {31'd0, per_en}, 32'd0);
                if (s == 3) rsp_ready = 1'b1;
                @(posedge mclk); #1;
            end
            rsp_ready = 1'b0;
        end
        chk("wrap_idle", {31'd0, cmd_ready}, 32'd1);

        // Asynchronous reset during RESP of beat 2 of a 4-beat burst
        rsp_ready = 1'b1;
        issue(9'h000, 1'b0, 1'b0, 16'h0000, 4'd3, 2'b00);
        @(posedge mclk); #1;
        @(posedge mclk); #1;
        chk("pre_rst_addr", {24'd0, per_addr}, 32'h01);
        @(posedge mclk); #1;
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("arst_last",  {31'd0, rsp_last}, 32'd0);
        chk("arst_bus",   {per_en, per_we, per_addr, per_din}, 32'd0);
        chk("arst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("arst_busy",  {31'd0, busy}, 32'd0);
        @(posedge mclk);
        @(negedge mclk) reset_n = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge mclk); #1;
            chk("post_rst_no_en", {31'd0, per_en}, 32'd0);
            chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        end
        run_vec(vecs[0]);

`ifdef PMST_RMW_EN
        mem[8'h2C] = 16'h000C;
        issue(9'h058, 1'b0, 1'b0, 16'h0002, 4'd0, 2'b01);
        chk("rmw_rd_en", {31'd0, per_en}, 32'd1);
        chk("rmw_rd_we", {30'd0, per_we}, 32'd0);
        @(posedge mclk); #1;
        chk("rmw_wr_en",  {31'd0, per_en}, 32'd1);
        chk("rmw_wr_we",  {30'd0, per_we}, 32'd3);
        chk("rmw_wr_din", {16'd0, per_din}, 32'h000E);
        @(posedge mclk); #1;
        chk("rmw_rsp",   {16'd0, rsp_rdata}, 32'h000C);
        chk("rmw_last",  {31'd0, rsp_last}, 32'd1);
        @(posedge mclk); #1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
